alu_scheduler: RTL and testbench

ALU_SCHEDULER -- requirements
Module: alu_scheduler

---
 rtl/alu_scheduler.sv | 159 +++++++++++++++
 tb/tb_alu_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_scheduler.sv
// Two-requester round-robin scheduler around a multi-cycle 32-bit adder (IDLE/EXEC/RESP).
// Define ALU_FLAGS_EN to compute and register the n/z/v flags; otherwise they are tied low.
module alu_scheduler #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req0_f,
  input  logic [3:0]  req1_f,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_s,
  output logic        rsp_c,
  output logic        rsp_n,
  output logic        rsp_z,
  output logic        rsp_v
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ptr_q;
  logic [31:0] a_q, b_q;
  logic [1:0]  op_q;
  logic        id_q;
  logic        grant_vld, grant_id, accept, capture;
  logic [31:0] add_x, add_y;
  logic        add_cin;
  logic [32:0] sum;
  logic        rsp_id_q, rsp_c_q;
  logic [31:0] rsp_s_q;
  logic        unused_fhi;

  assign unused_fhi = ^{req0_f[3:2], req1_f[3:2]};

  // Ties go to the requester that did not win last time.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) grant_id = ~ptr_q;
    else if (req1_valid)          grant_id = 1'b1;
  end

  assign accept  = (state_q == S_IDLE) && grant_vld;
  assign capture = (state_q == S_EXEC) && (cnt_q == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (grant_vld) begin
        state_d = S_EXEC;
        cnt_d   = CNT_INIT;
      end
      S_EXEC: if (cnt_q == 4'd0) state_d = S_RESP;
              else               cnt_d   = cnt_q - 4'd1;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = accept && !grant_id;
    req1_ready = accept &&  grant_id;
    rsp_valid  = (state_q == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b1;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      id_q  <= 1'b0;
    end else if (accept) begin
      ptr_q <= grant_id;
      id_q  <= grant_id;
      a_q   <= grant_id ? req1_a : req0_a;
      b_q   <= grant_id ? req1_b : req0_b;
      op_q  <= grant_id ? req1_f[1:0] : req0_f[1:0];
    end
  end

  always_comb begin
    add_x   = a_q;
    add_y   = b_q;
    add_cin = 1'b0;
    case (op_q)
      2'b00: ;
      2'b01: begin add_y = ~b_q; add_cin = 1'b1; end
      2'b10: begin add_x = '0; add_y = ~b_q; add_cin = 1'b1; end
      default: begin add_x = '0; add_cin = 1'b1; end
    endcase
    sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_q <= 1'b0;
      rsp_s_q  <= '0;
      rsp_c_q  <= 1'b0;
    end else if (capture) begin
      rsp_id_q <= id_q;
      rsp_s_q  <= sum[31:0];
      rsp_c_q  <= sum[32];
    end
  end

  assign rsp_id = rsp_id_q;
  assign rsp_s  = rsp_s_q;
  assign rsp_c  = rsp_c_q;

`ifdef ALU_FLAGS_EN
  logic rsp_n_q, rsp_z_q, rsp_v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_n_q <= 1'b0;
      rsp_z_q <= 1'b0;
      rsp_v_q <= 1'b0;
    end else if (capture) begin
      rsp_n_q <= sum[31];
      rsp_z_q <= (sum[31:0] == 32'd0);
      rsp_v_q <= (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);
    end
  end

  assign rsp_n = rsp_n_q;
  assign rsp_z = rsp_z_q;
  assign rsp_v = rsp_v_q;
`else
  assign rsp_n = 1'b0;
  assign rsp_z = 1'b0;
  assign rsp_v = 1'b0;
`endif

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: directed corner cases plus randomized transactions
// checked against an arithmetic reference model (flags expected only when ALU_FLAGS_EN is defined).
module tb_alu_scheduler;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_f, req1_f;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_c, rsp_n, rsp_z, rsp_v;
  logic [31:0] rsp_s;

  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;
  logic last_g;

  alu_scheduler #(.LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_f(req0_f), .req1_f(req1_f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_s(rsp_s), .rsp_c(rsp_c), .rsp_n(rsp_n), .rsp_z(rsp_z), .rsp_v(rsp_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Result from the operation's arithmetic meaning, not from the adder structure.
  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                                 output logic [31:0] s, output logic c, output logic n,
                                 output logic z, output logic v);
    longint sa, sb, sr;
    longint maxp = 64'sd2147483647;
    sa = $signed(a);
    sb = $signed(b);
    case (f[1:0])
      2'b00: begin {c, s} = {1'b0, a} + {1'b0, b}; sr = sa + sb; end
      2'b01: begin s = a - b; c = (a >= b); sr = sa - sb; end
      2'b10: begin s = -b; c = (b == 32'd0); sr = -sb; end
      default: begin s = b + 32'd1; c = (b == 32'hFFFF_FFFF); sr = sb + 1; end
    endcase
    n = s[31];
    z = (s == 32'd0);
    v = (sr > maxp) || (sr < -maxp - 1);
`ifndef ALU_FLAGS_EN
    n = 1'b0;
    z = 1'b0;
    v = 1'b0;
`endif
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, rsp_valid, 0);
    chk({tag, " id"}, rsp_id, 0);
    chk({tag, " s"}, rsp_s, 0);
    chk({tag, " c"}, rsp_c, 0);
    chk({tag, " n"}, rsp_n, 0);
    chk({tag, " z"}, rsp_z, 0);
    chk({tag, " v"}, rsp_v, 0);
    chk({tag, " rdy"}, {req0_ready, req1_ready}, 0);
  endtask

  // Called at a falling edge with the scheduler idle; returns at the falling edge after handshake.
  task automatic run_txn(input logic v0, input logic v1,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input logic [3:0] f0, input logic [3:0] f1,
                         input int stall, input string tag);
    logic        g;
    logic [31:0] ea, eb, es;
    logic [3:0]  ef;
    logic        ec, en, ez, ev;
    int          lat;
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req0_f = f0;
    req1_a = a1; req1_b = b1; req1_f = f1;
    rsp_ready = (stall == 0);
    #1;
    g = (v0 && v1) ? ~last_g : v1;
    chk({tag, " rdy0"}, req0_ready, !g);
    chk({tag, " rdy1"}, req1_ready, g);
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    ef = g ? f1 : f0;
    @(negedge clk);
    last_g = g;
    if (g) begin
      req1_valid = 1'b0; req1_a = $urandom; req1_b = $urandom; req1_f = 4'($urandom);
    end else begin
      req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom; req0_f = 4'($urandom);
    end
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      if (req0_ready || req1_ready) chk({tag, " busy rdy"}, {req0_ready, req1_ready}, 0);
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, LAT);
    ref_op(ea, eb, ef, es, ec, en, ez, ev);
    chk({tag, " id"}, rsp_id, g);
    chk({tag, " s"}, rsp_s, es);
    chk({tag, " c"}, rsp_c, ec);
    chk({tag, " n"}, rsp_n, en);
    chk({tag, " z"}, rsp_z, ez);
    chk({tag, " v"}, rsp_v, ev);
    for (int i = 0; i < stall; i++) begin
      req1_valid = 1'b1;
      req0_valid = 1'($urandom);
      @(negedge clk);
      chk({tag, " hold valid"}, rsp_valid, 1);
      chk({tag, " hold s"}, rsp_s, es);
      chk({tag, " hold id/c/nzv"}, {rsp_id, rsp_c, rsp_n, rsp_z, rsp_v}, {g, ec, en, ez, ev});
      chk({tag, " hold rdy"}, {req0_ready, req1_ready}, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, " bubble"}, rsp_valid, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    logic        rv0, rv1;
    logic [31:0] ra0, rb0, ra1, rb1;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_f = '0; req1_f = '0;
    rsp_ready = 1'b1;
    last_g = 1'b1;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(1, 0, 32'd5, 32'd3, 0, 0, 4'b0000, 4'b0000, 0, "add5+3");
    run_txn(0, 1, 0, 0, 32'd3, 32'd5, 4'b0000, 4'b0001, 0, "sub3-5");
    run_txn(0, 1, 0, 0, 32'd5, 32'd5, 4'b0000, 4'b0001, 0, "sub5-5");
    run_txn(1, 0, 32'h7FFF_FFFF, 32'd1, 0, 0, 4'b0000, 4'b0000, 0, "add_ovf");
    run_txn(1, 0, 32'd9, 32'hFFFF_FFFF, 0, 0, 4'b0011, 4'b0000, 0, "inc_wrap");
    run_txn(0, 1, 0, 0, 32'd1, 32'h8000_0000, 4'b0000, 4'b1110, 0, "neg_min");
    run_txn(1, 0, 32'd0, 32'd0, 0, 0, 4'b0110, 4'b0000, 0, "neg_zero");
    run_txn(1, 0, 32'h8000_0000, 32'd1, 0, 0, 4'b1101, 4'b0000, 0, "sub_ovf");

    for (int i = 0; i < 4; i++)
      run_txn(1, 1, $urandom, $urandom, $urandom, $urandom, 4'($urandom), 4'($urandom), 0, "rr");

    run_txn(1, 0, 32'd100, 32'd23, 0, 0, 4'b0001, 4'b0000, 5, "stall");
    run_txn(1, 1, 32'd1, 32'd2, 32'd3, 32'd4, 4'b0000, 4'b0000, 0, "after_stall");

    // Reset during EXEC must discard the operation and reset the tie pointer.
    req0_valid = 1'b1; req0_a = 32'd11; req0_b = 32'd22; req0_f = 4'b0000;
    @(negedge clk);
    req0_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_exec");
    @(negedge clk);
    rst_n = 1'b1;
    last_g = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      chk("rst_exec no rsp", rsp_valid, 0);
    end
    run_txn(1, 1, 32'd5, 32'd3, 32'd7, 32'd7, 4'b0000, 4'b0001, 0, "post_rst");

    for (int i = 0; i < 30; i++) begin
      rv0 = 1'($urandom);
      rv1 = 1'($urandom);
      if (!rv0 && !rv1) rv0 = 1'b1;
      ra0 = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
      rb0 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      rb1 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
      run_txn(rv0, rv1, ra0, rb0, ra1, rb1, 4'($urandom), 4'($urandom),
              int'($urandom_range(0, 3)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
